// File: rtl/uart_boot_sequencer_pkg.sv
// Shared definitions for the UART boot sequencer.
//   boot_state_t      : sequencer states; the encoding is exported on the debug/LED port
//   CLKS_PER_BIT      : UART bit period in system clocks (100 MHz / 9600 baud, rounded)
//   TAIL_CLKS_DEFAULT : clocks to keep the UART alive after its dump-done flag, long
//                       enough for the final 11-bit frame to leave the shifter
package uart_boot_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_IM   = 3'd1,
    ST_LOAD_DM   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_PREP = 3'd4,
    ST_DUMP      = 3'd5,
    ST_DUMP_TAIL = 3'd6,
    ST_DONE      = 3'd7
  } boot_state_t;

  localparam int unsigned CLKS_PER_BIT      = 10417;
  localparam int unsigned FRAME_BITS        = 11;
  localparam logic [31:0] TAIL_CLKS_DEFAULT = 32'(FRAME_BITS * CLKS_PER_BIT);

endpackage

// File: rtl/uart_boot_sequencer_boot_mem_mux.sv
// Combinational selection of the IM write port and the DM port between the UART
// loader/dumper and the CPU, driven only by the sequencer state.
//   state                       : current sequencer state
//   uart_on_received/addr/data  : UART word strobe, word address and received word
//   cpu_dm_we/addr/wdata        : CPU-side DM port
//   im_we/im_waddr/im_wdata     : IM write port (UART only)
//   dm_we/dm_addr/dm_wdata      : muxed DM port
module boot_mem_mux
  import uart_boot_sequencer_pkg::*;
#(
  parameter int ADDR_BITS = 9
) (
  input  boot_state_t          state,
  input  logic                 uart_on_received,
  input  logic [ADDR_BITS-1:0] uart_addr,
  input  logic [31:0]          uart_recv_data,
  input  logic                 cpu_dm_we,
  input  logic [ADDR_BITS-1:0] cpu_dm_addr,
  input  logic [31:0]          cpu_dm_wdata,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_waddr,
  output logic [31:0]          im_wdata,
  output logic                 dm_we,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [31:0]          dm_wdata
);

  // Write strobes pass straight through in the owning state so a received word
  // lands in memory in the same cycle; every other state parks the ports idle.
  always_comb begin
    im_we    = 1'b0;
    im_waddr = '0;
    im_wdata = '0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    case (state)
      ST_LOAD_IM: begin
        im_we    = uart_on_received;
        im_waddr = uart_addr;
        im_wdata = uart_recv_data;
      end
      ST_LOAD_DM: begin
        dm_we    = uart_on_received;
        dm_addr  = uart_addr;
        dm_wdata = uart_recv_data;
      end
      ST_RUN: begin
        dm_we    = cpu_dm_we;
        dm_addr  = cpu_dm_addr;
        dm_wdata = cpu_dm_wdata;
      end
      // During a dump the UART only reads DM; its send data comes from DM read data.
      ST_DUMP, ST_DUMP_TAIL: begin
        dm_addr = uart_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_boot_sequencer.sv
// Top-level boot controller: loads IM then DM over the UART, releases the CPU,
// and dumps DM back over the UART on CPU halt or on request.
//   clk, reset                        : system clock, async active-high reset
//   start_load, run_req, dump_req     : 1-cycle request pulses
//   cpu_halt                          : CPU has halted (level)
//   uart_im_done, uart_dm_done        : UART transfer-complete flags
//   uart_on_received/addr/recv_data   : UART word strobe, address and data
//   uart_en, uart_mode, uart_ram_id   : UART controls (mode 1 = send, ram_id 1 = DM)
//   cpu_reset                         : holds the CPU in reset
//   im_*                              : IM write port
//   cpu_dm_*                          : CPU-side DM port
//   dm_*                              : muxed DM port
//   state                             : current state encoding for LEDs/debug
module uart_boot_sequencer
  import uart_boot_sequencer_pkg::*;
#(
  parameter int          ADDR_BITS = 9,
  parameter logic [31:0] TAIL_CLKS = TAIL_CLKS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 run_req,
  input  logic                 dump_req,
  input  logic                 cpu_halt,
  input  logic                 uart_im_done,
  input  logic                 uart_dm_done,
  input  logic                 uart_on_received,
  input  logic [ADDR_BITS-1:0] uart_addr,
  input  logic [31:0]          uart_recv_data,
  output logic                 uart_en,
  output logic                 uart_mode,
  output logic                 uart_ram_id,
  output logic                 cpu_reset,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_waddr,
  output logic [31:0]          im_wdata,
  input  logic                 cpu_dm_we,
  input  logic [ADDR_BITS-1:0] cpu_dm_addr,
  input  logic [31:0]          cpu_dm_wdata,
  output logic                 dm_we,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [31:0]          dm_wdata,
  output logic [2:0]           state
);

  boot_state_t cur_state;
  boot_state_t next_state;
  logic [31:0] tail_cnt;
  logic        tail_last;

  assign tail_last = (tail_cnt == TAIL_CLKS - 32'd1);
  assign state     = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // The tail counter only runs inside DUMP_TAIL; holding it at zero elsewhere
  // means it is already cleared on the way in from DUMP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tail_cnt <= '0;
    end else if (cur_state == ST_DUMP_TAIL) begin
      tail_cnt <= tail_cnt + 32'd1;
    end else begin
      tail_cnt <= '0;
    end
  end

  // DUMP_PREP drops uart_en for one cycle so the UART forgets its done flags and
  // address before it starts sending. Requests not listed for a state are dropped.
  always_comb begin
    next_state  = cur_state;
    uart_en     = 1'b0;
    uart_mode   = 1'b0;
    uart_ram_id = 1'b0;
    cpu_reset   = 1'b1;
    case (cur_state)
      ST_IDLE: begin
        if (start_load)   next_state = ST_LOAD_IM;
        else if (run_req) next_state = ST_RUN;
      end
      ST_LOAD_IM: begin
        uart_en = 1'b1;
        if (uart_im_done) next_state = ST_LOAD_DM;
      end
      ST_LOAD_DM: begin
        uart_en     = 1'b1;
        uart_ram_id = 1'b1;
        if (uart_dm_done) next_state = ST_RUN;
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (cpu_halt || dump_req) next_state = ST_DUMP_PREP;
      end
      ST_DUMP_PREP: begin
        next_state = ST_DUMP;
      end
      ST_DUMP: begin
        uart_en     = 1'b1;
        uart_mode   = 1'b1;
        uart_ram_id = 1'b1;
        if (uart_dm_done) next_state = ST_DUMP_TAIL;
      end
      ST_DUMP_TAIL: begin
        uart_en     = 1'b1;
        uart_mode   = 1'b1;
        uart_ram_id = 1'b1;
        if (tail_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (start_load)    next_state = ST_LOAD_IM;
        else if (run_req)  next_state = ST_RUN;
        else if (dump_req) next_state = ST_DUMP_PREP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  boot_mem_mux #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_mux (
    .state            (cur_state),
    .uart_on_received (uart_on_received),
    .uart_addr        (uart_addr),
    .uart_recv_data   (uart_recv_data),
    .cpu_dm_we        (cpu_dm_we),
    .cpu_dm_addr      (cpu_dm_addr),
    .cpu_dm_wdata     (cpu_dm_wdata),
    .im_we            (im_we),
    .im_waddr         (im_waddr),
    .im_wdata         (im_wdata),
    .dm_we            (dm_we),
    .dm_addr          (dm_addr),
    .dm_wdata         (dm_wdata)
  );

endmodule
